// File: rtl/sram_axi_bist_master.sv
// AXI4 BIST master: fills an SRAM window with P(a) = (a >> 2) ^ seed, reads it back, counts errors.
// Optional feature macro SRAM_AXI_BIST_INVERT_PASS_EN adds a second write/read pass using ~P(a).
module sram_axi_bist_master #(
    parameter int unsigned BW_ADDR    = 32,
    parameter int unsigned BW_DATA    = 32,
    parameter int unsigned BW_AXI_TID = 4,
    parameter int unsigned BASEADDR   = 0,
    parameter int unsigned TEST_BYTES = 131072,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BW_DATA-1:0]    seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [BW_ADDR-1:0]    first_err_addr,
    output logic [BW_AXI_TID-1:0] sxawid,
    output logic [BW_ADDR-1:0]    sxawaddr,
    output logic [7:0]            sxawlen,
    output logic [2:0]            sxawsize,
    output logic [1:0]            sxawburst,
    output logic                  sxawvalid,
    input  logic                  sxawready,
    output logic [BW_AXI_TID-1:0] sxwid,
    output logic [BW_DATA-1:0]    sxwdata,
    output logic [3:0]            sxwstrb,
    output logic                  sxwlast,
    output logic                  sxwvalid,
    input  logic                  sxwready,
    input  logic [BW_AXI_TID-1:0] sxbid,
    input  logic [1:0]            sxbresp,
    input  logic                  sxbvalid,
    output logic                  sxbready,
    output logic [BW_AXI_TID-1:0] sxarid,
    output logic [BW_ADDR-1:0]    sxaraddr,
    output logic [7:0]            sxarlen,
    output logic [2:0]            sxarsize,
    output logic [1:0]            sxarburst,
    output logic                  sxarvalid,
    input  logic                  sxarready,
    input  logic [BW_AXI_TID-1:0] sxrid,
    input  logic [BW_DATA-1:0]    sxrdata,
    input  logic [1:0]            sxrresp,
    input  logic                  sxrlast,
    input  logic                  sxrvalid,
    output logic                  sxrready
);

    typedef enum logic [2:0] {StIdle, StWa, StWd, StWb, StRa, StRd, StFin} state_e;

    localparam logic [7:0]         Len        = 8'(BURST_LEN - 1);
    localparam logic [3:0]         LastBeat   = 4'(BURST_LEN - 1);
    localparam logic [BW_ADDR-1:0] BaseAddr   = BW_ADDR'(BASEADDR);
    localparam logic [BW_ADDR-1:0] EndAddr    = BW_ADDR'(BASEADDR + TEST_BYTES);
    localparam logic [BW_ADDR-1:0] BurstBytes = BW_ADDR'(4 * BURST_LEN);

    state_e               state_q, state_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d;
    logic [3:0]           beat_q, beat_d;
    logic [BW_DATA-1:0]   seed_q, seed_d;
    logic [15:0]          err_q, err_d;
    logic [BW_ADDR-1:0]   ferr_q, ferr_d;
    logic                 awvalid_q, awvalid_d;
    logic [BW_ADDR-1:0]   awaddr_q, awaddr_d;
    logic [7:0]           awlen_q, awlen_d;
    logic                 arvalid_q, arvalid_d;
    logic [BW_ADDR-1:0]   araddr_q, araddr_d;
    logic [7:0]           arlen_q, arlen_d;
    logic                 wvalid_q, wvalid_d;
    logic [BW_DATA-1:0]   wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 wlast_q, wlast_d;
    logic                 inv;
    logic                 err_hit;
    logic [BW_ADDR-1:0]   err_addr;
    logic [BW_ADDR-1:0]   beat_off;
    logic [BW_ADDR-1:0]   next_burst;
    logic                 window_end;
    logic                 rd_bad;
    logic                 unused_ok;

`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
    logic inv_q, inv_d;
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    function automatic logic [BW_DATA-1:0] pat(input logic [BW_ADDR-1:0] a,
                                               input logic [BW_DATA-1:0] s, input logic i);
        return BW_DATA'(a >> 2) ^ s ^ {BW_DATA{i}};
    endfunction

    assign beat_off   = BW_ADDR'({beat_q, 2'b00});
    assign next_burst = addr_q + BurstBytes;
    assign window_end = (next_burst == EndAddr);
    // Several faults on one beat collapse into a single error.
    assign rd_bad     = (sxrdata != pat(addr_q + beat_off, seed_q, inv)) || (sxrresp != 2'b00) ||
                        (sxrlast != (beat_q == LastBeat));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        seed_d    = seed_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wlast_d   = wlast_q;
        err_hit   = 1'b0;
        err_addr  = addr_q;
`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    state_d = StWa;
                    addr_d  = BaseAddr;
                    seed_d  = seed;
                    err_d   = 16'd0;
                    ferr_d  = '0;
`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            StWa: begin
                if (!awvalid_q) begin
                    awvalid_d = 1'b1;
                    awaddr_d  = addr_q;
                    awlen_d   = Len;
                end else if (sxawready) begin
                    awvalid_d = 1'b0;
                    state_d   = StWd;
                    beat_d    = 4'd0;
                    wvalid_d  = 1'b1;
                    wdata_d   = pat(addr_q, seed_q, inv);
                    wstrb_d   = 4'hF;
                    wlast_d   = (LastBeat == 4'd0);
                end
            end
            StWd: begin
                if (sxwready) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        state_d  = StWb;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        wdata_d = pat(addr_q + BW_ADDR'({beat_q + 4'd1, 2'b00}), seed_q, inv);
                        wlast_d = ((beat_q + 4'd1) == LastBeat);
                    end
                end
            end
            StWb: begin
                if (sxbvalid) begin
                    err_hit = (sxbresp != 2'b00);
                    if (window_end) begin
                        addr_d  = BaseAddr;
                        state_d = StRa;
                    end else begin
                        addr_d  = next_burst;
                        state_d = StWa;
                    end
                end
            end
            StRa: begin
                if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    arlen_d   = Len;
                end else if (sxarready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRd;
                    beat_d    = 4'd0;
                end
            end
            StRd: begin
                if (sxrvalid) begin
                    err_hit  = rd_bad;
                    err_addr = addr_q + beat_off;
                    if (beat_q == LastBeat) begin
                        beat_d = 4'd0;
                        addr_d = next_burst;
                        if (window_end) begin
`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
                            if (!inv_q) begin
                                inv_d   = 1'b1;
                                addr_d  = BaseAddr;
                                state_d = StWa;
                            end else begin
                                state_d = StFin;
                            end
`else
                            state_d = StFin;
`endif
                        end else begin
                            state_d = StRa;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (err_hit) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) ferr_d = err_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            beat_q    <= 4'd0;
            seed_q    <= '0;
            err_q     <= 16'd0;
            ferr_q    <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= 8'd0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= 8'd0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= 4'h0;
            wlast_q   <= 1'b0;
`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wlast_q   <= wlast_d;
`ifdef SRAM_AXI_BIST_INVERT_PASS_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign busy           = (state_q != StIdle) && (state_q != StFin);
    assign done           = (state_q == StFin);
    assign pass           = done && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

    assign sxawid    = '0;
    assign sxawaddr  = awaddr_q;
    assign sxawlen   = awlen_q;
    assign sxawsize  = 3'd2;
    assign sxawburst = 2'd1;
    assign sxawvalid = awvalid_q;
    assign sxwid     = '0;
    assign sxwdata   = wdata_q;
    assign sxwstrb   = wstrb_q;
    assign sxwlast   = wlast_q;
    assign sxwvalid  = wvalid_q;
    assign sxbready  = (state_q == StWb);
    assign sxarid    = '0;
    assign sxaraddr  = araddr_q;
    assign sxarlen   = arlen_q;
    assign sxarsize  = 3'd2;
    assign sxarburst = 2'd1;
    assign sxarvalid = arvalid_q;
    assign sxrready  = (state_q == StRd);

    assign unused_ok = ^{sxbid, sxrid};

endmodule
